nott_pulse_scheduler: RTL and testbench
=======================================

Name: nott_pulse_scheduler

Overview:
- Synchronous controller that sequences pulse delivery to one NOT-T (clocked inverter / toggle) cell.
- Arbitrates A-pulse and CLK-pulse requests from N_REQ requesters and issues at most one pulse per cycle.
- Enforces the cell's critical-timing windows as minimum cycle spacings, so the cell never receives a violating pulse.
- Keeps a mirror of the cell's internal state and its predicted output q. Sits between test-pattern/sequencing logic and the cell's a/clk drivers.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CT_CLK_A, 8, minimum cycles from a state-0 clk_pulse to the next a_pulse.
- CT_CLK_CLK, 12, minimum cycles from a state-0 clk_pulse to the next clk_pulse.
- CT_A_CLK, 8, minimum cycles from a state-1 a_pulse to the next clk_pulse.
- DLY_CLK_Q, 14, cycles from a state-0 clk_pulse to the q_pred toggle (1..63).
- CNT_W, 16, width of pulse_cnt.

Ports:
- clk, in, 1, system clock; all logic on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, N_REQ, per-requester request; held high until granted.
- req_kind, in, N_REQ, per-requester pulse type: 0 = A, 1 = CLK. Must stay stable while valid.
- req_ready, out, N_REQ, one-hot grant, combinational; transfer occurs when valid & ready.
- a_pulse, out, 1, registered one-cycle A pulse to the cell.
- clk_pulse, out, 1, registered one-cycle CLK pulse to the cell.
- grant_id, out, 3, registered index of the requester that caused the current pulse.
- cell_state, out, 1, mirror of the cell's internal state.
- q_pred, out, 1, predicted cell output.
- pulse_cnt, out, CNT_W, total pulses issued, wraps modulo 2^CNT_W.

Behaviour:

Reset (rst_n low, asynchronous):
- a_pulse = clk_pulse = 0, grant_id = 0, cell_state = 0, q_pred = 0, pulse_cnt = 0.
- All hold-off counters are cleared (no windows open).
- Pending q toggles are discarded.
- Round-robin pointer = 0.
- req_ready = 0 while rst_n is low.
- Assertion mid-operation aborts everything; nothing resumes after release.

Eligibility (evaluated each cycle):
- An A request is eligible when the A hold-off has expired.
- A CLK request is eligible when the CLK hold-off has expired.

Arbitration:
- Round-robin over eligible requesters, starting the search at the pointer.
- At most one req_ready bit is high.
- On a grant to index g, the pointer becomes (g+1) mod N_REQ.
- Ineligible requests wait; they are never dropped and raise no error.

Issue (grant at cycle t):
- The matching pulse is high for exactly cycle t+1.
- grant_id = g during t+1.
- pulse_cnt increments at t+1.
- a_pulse and clk_pulse are never both high.

Mirror state machine (updates at the pulse cycle P):

State 0:
- a_pulse: go to state 1. No window opens.
- clk_pulse: stay in state 0.
  - Schedule a q_pred toggle at P+DLY_CLK_Q.
  - Next a_pulse is allowed no earlier than P+CT_CLK_A.
  - Next clk_pulse is allowed no earlier than P+CT_CLK_CLK.

State 1:
- a_pulse: stay in state 1.
  - Next clk_pulse is allowed no earlier than P+CT_A_CLK.
- clk_pulse: go to state 0. No toggle is scheduled and no window opens.

Hold-off details:
- A new window that overlaps an open window keeps the later expiry (max).
- Hold-offs gate grants so the resulting pulse lands at or after the expiry cycle.
- Exact spacing is achieved, not exceeded: a continuously pending request pulses exactly at the expiry cycle.

q toggle pipeline:
- Delay line of depth DLY_CLK_Q.
- Multiple toggles may be in flight, since CT_CLK_CLK < DLY_CLK_Q is legal.
- Each in-flight toggle inverts q_pred exactly once, at its own cycle.

Simultaneous events:
- A toggle maturing in the same cycle as a new pulse: both take effect.
- Requests from several requesters in one cycle: only one is granted.

Test Plan:
1. Reset, then req0 = CLK alone: grant at cycle 1, clk_pulse at 2, q_pred 0→1 at 16, cell_state stays 0, pulse_cnt = 1.
2. CLK pulse at P=2, with req1 = A pending from cycle 3: a_pulse exactly at cycle 10 (P+8), not earlier; cell_state = 1 from cycle 10.
3. From state 1, A at P=20, with req2 = CLK pending: clk_pulse exactly at 28; cell_state returns to 0; no q toggle; no new windows; an A requested immediately after is pulsed next cycle.
4. Back-to-back CLK requests in state 0: clk_pulses at 2 and 14; q_pred toggles at 16 and 28 (two in flight); final q_pred = 0.
5. All 4 requesters valid with kind = A from reset: grants 0,1,2,3,0 on consecutive cycles; a_pulse every cycle; grant_id sequence 0,1,2,3; cell_state = 1.
6. rst_n low at cycle 8, with a toggle pending for cycle 16 and a window open: all outputs return to reset values immediately; no q_pred change at 16; a CLK granted after release pulses one cycle later with no hold-off.

Source files
------------

// File: rtl/nott_pulse_scheduler_if.sv
// Request/grant bundle between sequencing logic and the NOT-T pulse scheduler.
// Master drives requests; the scheduler (slave) returns a one-hot ready.
interface nott_pulse_scheduler_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_kind;
    logic [N_REQ-1:0] req_ready;

    modport master (
        output req_valid,
        output req_kind,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_kind,
        output req_ready
    );
endinterface

// File: rtl/nott_pulse_scheduler.sv
// Round-robin A/CLK pulse scheduler for one NOT-T cell, enforcing timing
// windows and mirroring the cell state and its predicted output.
module nott_pulse_scheduler #(
    parameter int N_REQ      = 4,
    parameter int CT_CLK_A   = 8,
    parameter int CT_CLK_CLK = 12,
    parameter int CT_A_CLK   = 8,
    parameter int DLY_CLK_Q  = 14,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    nott_pulse_scheduler_if.slave rq,
    output logic             a_pulse,
    output logic             clk_pulse,
    output logic [2:0]       grant_id,
    output logic             cell_state,
    output logic             q_pred,
    output logic [CNT_W-1:0] pulse_cnt
);

    localparam int CT_M1 = (CT_CLK_A > CT_CLK_CLK) ? CT_CLK_A : CT_CLK_CLK;
    localparam int CT_MAX = (CT_M1 > CT_A_CLK) ? CT_M1 : CT_A_CLK;
    localparam int HW = (CT_MAX < 2) ? 1 : $clog2(CT_MAX);

    typedef enum logic {S0, S1} state_t;

    state_t               state_q;
    logic                 a_pulse_q, clk_pulse_q, q_q;
    logic [2:0]           gid_q, ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [HW-1:0]        a_hold_q, c_hold_q, a_hold_d, c_hold_d;
    logic [HW-1:0]        a_dec, c_dec;
    logic [DLY_CLK_Q-1:0] dl_q;
    logic [N_REQ-1:0]     elig;
    logic                 gnt, gkind, is_a, is_clk, tog_new;
    logic [2:0]           gid;

    function automatic logic [HW-1:0] hmax(
        input logic [HW-1:0] x,
        input logic [HW-1:0] y
    );
        return (x > y) ? x : y;
    endfunction

    // Holds count down to the cycle before the pulse may land.
    assign a_dec = (a_hold_q != '0) ? a_hold_q - HW'(1) : '0;
    assign c_dec = (c_hold_q != '0) ? c_hold_q - HW'(1) : '0;

    always_comb begin
        elig = '0;
        for (int k = 0; k < N_REQ; k++) begin
            elig[k] = rq.req_valid[k] &&
                      (rq.req_kind[k] ? (c_hold_q == '0)
                                      : (a_hold_q == '0));
        end
    end

    always_comb begin
        gnt   = 1'b0;
        gid   = '0;
        gkind = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!gnt && elig[k] && k >= int'(ptr_q)) begin
                gnt   = 1'b1;
                gid   = 3'(k);
                gkind = rq.req_kind[k];
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (!gnt && elig[k]) begin
                gnt   = 1'b1;
                gid   = 3'(k);
                gkind = rq.req_kind[k];
            end
        end
        if (!rst_n) gnt = 1'b0;
    end

    assign rq.req_ready = gnt ? (N_REQ'(1) << gid) : '0;
    assign is_a   = gnt & ~gkind;
    assign is_clk = gnt & gkind;

    always_comb begin
        a_hold_d = a_dec;
        c_hold_d = c_dec;
        tog_new  = 1'b0;
        if (is_a && state_q == S1) begin
            c_hold_d = hmax(c_dec, HW'(CT_A_CLK - 1));
        end
        if (is_clk && state_q == S0) begin
            a_hold_d = hmax(a_dec, HW'(CT_CLK_A - 1));
            c_hold_d = hmax(c_dec, HW'(CT_CLK_CLK - 1));
            tog_new  = 1'b1;
        end
        ptr_d = ptr_q;
        if (gnt) ptr_d = (gid == 3'(N_REQ - 1)) ? 3'd0 : gid + 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S0;
            a_pulse_q   <= 1'b0;
            clk_pulse_q <= 1'b0;
            gid_q       <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            a_hold_q    <= '0;
            c_hold_q    <= '0;
            dl_q        <= '0;
            q_q         <= 1'b0;
        end else begin
            a_pulse_q   <= is_a;
            clk_pulse_q <= is_clk;
            a_hold_q    <= a_hold_d;
            c_hold_q    <= c_hold_d;
            ptr_q       <= ptr_d;
            dl_q        <= (dl_q << 1) | DLY_CLK_Q'(tog_new);
            q_q         <= q_q ^ dl_q[DLY_CLK_Q-1];
            if (gnt) begin
                gid_q <= gid;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (is_a) state_q <= S1;
            else if (is_clk) state_q <= S0;
        end
    end

    assign a_pulse    = a_pulse_q;
    assign clk_pulse  = clk_pulse_q;
    assign grant_id   = gid_q;
    assign cell_state = (state_q == S1);
    assign q_pred     = q_q;
    assign pulse_cnt  = cnt_q;

endmodule

// File: tb/tb_nott_pulse_scheduler.sv
// Directed bench for nott_pulse_scheduler: windows, q toggles, round-robin
// and asynchronous reset, with hand-computed cycle numbers.
module tb_nott_pulse_scheduler;

    logic        clk;
    logic        rst_n;
    logic        a_pulse, clk_pulse, cell_state, q_pred;
    logic [2:0]  grant_id;
    logic [15:0] pulse_cnt;
    logic [3:0]  granted;
    bit          auto_drop;
    int          cyc, checks, fails;

    nott_pulse_scheduler_if #(.N_REQ(4)) rq ();

    nott_pulse_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rq         (rq),
        .a_pulse    (a_pulse),
        .clk_pulse  (clk_pulse),
        .grant_id   (grant_id),
        .cell_state (cell_state),
        .q_pred     (q_pred),
        .pulse_cnt  (pulse_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        #4;
        granted = rq.req_valid & rq.req_ready;
        @(posedge clk);
        #1;
        if (auto_drop) rq.req_valid = rq.req_valid & ~granted;
        cyc++;
    endtask

    task automatic do_reset();
        rq.req_valid = '0;
        rq.req_kind  = '0;
        auto_drop    = 1'b1;
        rst_n        = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a_pulse, clk_pulse, cell_state, q_pred} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {a_pulse, clk_pulse, cell_state, q_pred});
        end
        checks++;
        if (pulse_cnt !== 16'd0 || grant_id !== 3'd0) begin
            fails++;
            $display("FAIL reset_cnt_gid got=%0d/%0d exp=0/0",
                     pulse_cnt, grant_id);
        end
    endtask

    task automatic test_clk_single();
        do_reset();
        tick();
        rq.req_valid[0] = 1'b1;
        rq.req_kind[0]  = 1'b1;
        tick();
        checks++;
        if (granted !== 4'b0001) begin
            fails++;
            $display("FAIL t1_grant got=%b exp=0001", granted);
        end
        checks++;
        if ({clk_pulse, a_pulse, cell_state} !== 3'b100 ||
            pulse_cnt !== 16'd1) begin
            fails++;
            $display("FAIL t1_pulse got=%b cnt=%0d exp=100 cnt=1",
                     {clk_pulse, a_pulse, cell_state}, pulse_cnt);
        end
        while (cyc < 15) tick();
        checks++;
        if (q_pred !== 1'b0) begin
            fails++;
            $display("FAIL t1_q15 got=%b exp=0", q_pred);
        end
        tick();
        checks++;
        if (q_pred !== 1'b1 || cell_state !== 1'b0) begin
            fails++;
            $display("FAIL t1_q16 got=%b/%b exp=1/0", q_pred, cell_state);
        end
    endtask

    task automatic test_clk_to_a();
        int seen;
        logic cs9, cs10;
        seen = -1;
        cs9  = 1'bx;
        cs10 = 1'bx;
        do_reset();
        tick();
        rq.req_valid[0] = 1'b1;
        rq.req_kind[0]  = 1'b1;
        tick();
        tick();
        rq.req_valid[1] = 1'b1;
        rq.req_kind[1]  = 1'b0;
        while (cyc < 40 && seen < 0) begin
            tick();
            if (cyc == 9) cs9 = cell_state;
            if (cyc == 10) cs10 = cell_state;
            if (a_pulse) seen = cyc;
        end
        checks++;
        if (seen !== 10) begin
            fails++;
            $display("FAIL t2_a_cycle got=%0d exp=10", seen);
        end
        checks++;
        if (cs9 !== 1'b0 || cs10 !== 1'b1) begin
            fails++;
            $display("FAIL t2_state got=%b%b exp=01", cs9, cs10);
        end
    endtask

    task automatic test_a_to_clk();
        int a1_at, clk_at, a2_at;
        logic cs_clk, qseen;
        a1_at  = -1;
        clk_at = -1;
        a2_at  = -1;
        cs_clk = 1'bx;
        qseen  = 1'b0;
        do_reset();
        tick();
        rq.req_valid[0] = 1'b1;
        rq.req_kind[0]  = 1'b0;
        while (cyc < 19) tick();
        rq.req_valid[1] = 1'b1;
        rq.req_kind[1]  = 1'b0;
        rq.req_valid[2] = 1'b1;
        rq.req_kind[2]  = 1'b1;
        while (cyc < 45) begin
            tick();
            if (q_pred) qseen = 1'b1;
            if (a_pulse && cyc < 29 && a1_at < 0) a1_at = cyc;
            if (clk_pulse && clk_at < 0) begin
                clk_at = cyc;
                cs_clk = cell_state;
            end
            if (a_pulse && cyc > 29 && a2_at < 0) a2_at = cyc;
            if (cyc == 29) begin
                rq.req_valid[3] = 1'b1;
                rq.req_kind[3]  = 1'b0;
            end
        end
        checks++;
        if (a1_at !== 20 || clk_at !== 28) begin
            fails++;
            $display("FAIL t3_spacing got a=%0d clk=%0d exp a=20 clk=28",
                     a1_at, clk_at);
        end
        checks++;
        if (cs_clk !== 1'b0 || a2_at !== 30) begin
            fails++;
            $display("FAIL t3_after got cs=%b a=%0d exp cs=0 a=30",
                     cs_clk, a2_at);
        end
        checks++;
        if (qseen !== 1'b0) begin
            fails++;
            $display("FAIL t3_no_toggle got=%b exp=0", qseen);
        end
    endtask

    task automatic test_back_to_back();
        int p[4], t[4];
        int np, nt;
        logic prev_q;
        np = 0;
        nt = 0;
        p  = '{-1, -1, -1, -1};
        t  = '{-1, -1, -1, -1};
        do_reset();
        tick();
        rq.req_valid = 4'b0011;
        rq.req_kind  = 4'b0011;
        prev_q = q_pred;
        while (cyc < 32) begin
            tick();
            if (clk_pulse) begin
                if (np < 4) p[np] = cyc;
                np++;
            end
            if (q_pred !== prev_q) begin
                if (nt < 4) t[nt] = cyc;
                nt++;
            end
            prev_q = q_pred;
        end
        checks++;
        if (np !== 2 || p[0] !== 2 || p[1] !== 14) begin
            fails++;
            $display("FAIL t4_pulses got n=%0d %0d,%0d exp n=2 2,14",
                     np, p[0], p[1]);
        end
        checks++;
        if (nt !== 2 || t[0] !== 16 || t[1] !== 28 || q_pred !== 1'b0) begin
            fails++;
            $display("FAIL t4_toggles got n=%0d %0d,%0d q=%b exp 2 16,28 0",
                     nt, t[0], t[1], q_pred);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        auto_drop    = 1'b0;
        rq.req_valid = 4'hF;
        rq.req_kind  = 4'h0;
        for (int i = 0; i < 5; i++) begin
            exp_g = 4'b0001 << (i % 4);
            tick();
            checks++;
            if (granted !== exp_g || a_pulse !== 1'b1 ||
                clk_pulse !== 1'b0 || grant_id !== 3'(i % 4)) begin
                fails++;
                $display("FAIL t5_rr%0d got g=%b a=%b gid=%0d exp g=%b a=1 gid=%0d",
                         i, granted, a_pulse, grant_id, exp_g, i % 4);
            end
        end
        checks++;
        if (pulse_cnt !== 16'd5 || cell_state !== 1'b1) begin
            fails++;
            $display("FAIL t5_end got cnt=%0d cs=%b exp cnt=5 cs=1",
                     pulse_cnt, cell_state);
        end
        rq.req_valid = '0;
        auto_drop    = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick();
        rq.req_valid[0] = 1'b1;
        rq.req_kind[0]  = 1'b1;
        tick();
        tick();
        rq.req_valid[1] = 1'b1;
        rq.req_kind[1]  = 1'b1;
        while (cyc < 8) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_pulse, clk_pulse, cell_state, q_pred} !== 4'b0000 ||
            pulse_cnt !== 16'd0 || grant_id !== 3'd0 ||
            rq.req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL t6_async got f=%b cnt=%0d rdy=%b exp 0000/0/0000",
                     {a_pulse, clk_pulse, cell_state, q_pred},
                     pulse_cnt, rq.req_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (granted !== 4'b0010 || clk_pulse !== 1'b1 ||
            pulse_cnt !== 16'd1) begin
            fails++;
            $display("FAIL t6_release got g=%b clk=%b cnt=%0d exp 0010/1/1",
                     granted, clk_pulse, pulse_cnt);
        end
        while (cyc < 17) begin
            tick();
            if (cyc >= 15) begin
                checks++;
                if (q_pred !== 1'b0) begin
                    fails++;
                    $display("FAIL t6_no_toggle cyc=%0d got=%b exp=0",
                             cyc, q_pred);
                end
            end
        end
    endtask

    initial begin
        checks       = 0;
        fails        = 0;
        cyc          = 0;
        rst_n        = 1'b0;
        auto_drop    = 1'b1;
        rq.req_valid = '0;
        rq.req_kind  = '0;
        test_reset();
        test_clk_single();
        test_clk_to_a();
        test_a_to_clk();
        test_back_to_back();
        test_round_robin();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
